vmacc_seq_unit: RTL and testbench

//  Sequential, parametrised vector multiply-accumulate: vd[i] = vs2[i]*vs1[i] + acc[i] for i < vl.

---
 rtl/vmacc_seq_unit.sv | 148 ++++++++++++++
 tb/tb_vmacc_seq_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vmacc_seq_unit.sv
// vmacc_seq_unit: sequential vector multiply-accumulate vd[i] = vs2[i]*vs1[i] + acc[i] over one VLEN slice per cycle
// Ports: clk, rst (sync, active-high); in_valid/in_ready request handshake; sew (00 e8, 01 e16, 10 e32),
//   lmul (group of 1/2/4/8 registers), vl (clamped to VLMAX); vs2_bus, vs1_bus, acc_bus operand groups;
//   out_valid/out_ready result handshake; vd_bus result group; err flags illegal sew/lmul when out_valid.
// Build option: define VMACC_SAT_EN for signed saturating accumulate; default is unsigned modulo wrap.
module vmacc_seq_unit #(
  parameter int VLEN_BITS = 128,
  parameter int MAX_LMUL  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [1:0]                      sew,
  input  logic [1:0]                      lmul,
  input  logic [15:0]                     vl,
  input  logic [VLEN_BITS*MAX_LMUL-1:0]   vs2_bus,
  input  logic [VLEN_BITS*MAX_LMUL-1:0]   vs1_bus,
  input  logic [VLEN_BITS*MAX_LMUL-1:0]   acc_bus,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [VLEN_BITS*MAX_LMUL-1:0]   vd_bus,
  output logic                            err
);
  localparam int W  = VLEN_BITS * MAX_LMUL;
  localparam int NB = VLEN_BITS / 8;
  localparam int NH = VLEN_BITS / 16;
  localparam int NW = VLEN_BITS / 32;
`ifdef VMACC_SAT_EN
  localparam int R = 2;
`else
  localparam int R = 1;
`endif
  localparam int LW = 32 * R;
  localparam int PW = VLEN_BITS * R;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t               state;
  logic [1:0]           sew_q;
  logic [2:0]           k, last_q, s1_k;
  logic [31:0]          vl_q, vlmax;
  logic [W-1:0]         vs2_q, vs1_q;
  logic [VLEN_BITS-1:0] a_s, b_s, acc_s, res;
  logic [PW-1:0]        prod_d, prod;
  logic                 s1_v, legal;
`ifdef VMACC_SAT_EN
  // Signed lanes: full 2*SEW product, sign-extended acc, saturate to SEW.
  function automatic logic [LW-1:0] mul_lane(input logic [31:0] a, input logic [31:0] b, input int s);
    logic [63:0] as, bs;
    as = $signed({a << (32 - s), 32'd0}) >>> (64 - s);
    bs = $signed({b << (32 - s), 32'd0}) >>> (64 - s);
    return as * bs;
  endfunction
  function automatic logic [31:0] add_lane(input logic [LW-1:0] p, input logic [31:0] a, input int s);
    logic signed [65:0] ps, as, sum, mx;
    ps = $signed({p << (64 - 2 * s), 2'b00}) >>> (66 - 2 * s);
    as = $signed({a << (32 - s), 34'd0}) >>> (66 - s);
    sum = ps + as;
    mx = (66'sd1 <<< (s - 1)) - 66'sd1;
    return sum > mx ? 32'(mx) : sum < -mx - 66'sd1 ? 32'(-mx - 66'sd1) : 32'(sum);
  endfunction
`else
  function automatic logic [LW-1:0] mul_lane(input logic [31:0] a, input logic [31:0] b, input int s);
    return (a * b) & (s == 32 ? 32'hFFFF_FFFF : (32'd1 << s) - 32'd1);
  endfunction
  function automatic logic [31:0] add_lane(input logic [LW-1:0] p, input logic [31:0] a, input int s);
    return (p + a) & (s == 32 ? 32'hFFFF_FFFF : (32'd1 << s) - 32'd1);
  endfunction
`endif
  assign legal = sew != 2'b11 && (32'd1 << lmul) <= 32'(MAX_LMUL);
  assign vlmax = ((32'd1 << lmul) * 32'(VLEN_BITS)) >> ({1'b0, sew} + 3'd3);
  always_comb begin
    a_s = vs2_q[k*VLEN_BITS +: VLEN_BITS];
    b_s = vs1_q[k*VLEN_BITS +: VLEN_BITS];
    prod_d = '0;
    for (int j = 0; j < NB; j++)
      if (sew_q == 2'd0) prod_d[j*8*R +: 8*R] = (8*R)'(mul_lane(32'(a_s[j*8 +: 8]), 32'(b_s[j*8 +: 8]), 8));
    for (int j = 0; j < NH; j++)
      if (sew_q == 2'd1) prod_d[j*16*R +: 16*R] = (16*R)'(mul_lane(32'(a_s[j*16 +: 16]), 32'(b_s[j*16 +: 16]), 16));
    for (int j = 0; j < NW; j++)
      if (sew_q == 2'd2) prod_d[j*32*R +: 32*R] = (32*R)'(mul_lane(a_s[j*32 +: 32], b_s[j*32 +: 32], 32));
  end
  // vd_bus is loaded with acc on accept and each slice is overwritten once, so it doubles as the acc store.
  always_comb begin
    acc_s = vd_bus[s1_k*VLEN_BITS +: VLEN_BITS];
    res = acc_s;
    for (int j = 0; j < NB; j++)
      if (sew_q == 2'd0 && 32'(s1_k) * 32'(NB) + 32'(j) < vl_q)
        res[j*8 +: 8] = 8'(add_lane(LW'(prod[j*8*R +: 8*R]), 32'(acc_s[j*8 +: 8]), 8));
    for (int j = 0; j < NH; j++)
      if (sew_q == 2'd1 && 32'(s1_k) * 32'(NH) + 32'(j) < vl_q)
        res[j*16 +: 16] = 16'(add_lane(LW'(prod[j*16*R +: 16*R]), 32'(acc_s[j*16 +: 16]), 16));
    for (int j = 0; j < NW; j++)
      if (sew_q == 2'd2 && 32'(s1_k) * 32'(NW) + 32'(j) < vl_q)
        res[j*32 +: 32] = add_lane(LW'(prod[j*32*R +: 32*R]), acc_s[j*32 +: 32], 32);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      err       <= 1'b0;
      vd_bus    <= '0;
      k         <= '0;
      last_q    <= '0;
      s1_k      <= '0;
      s1_v      <= 1'b0;
      prod      <= '0;
      sew_q     <= '0;
      vl_q      <= '0;
      vs2_q     <= '0;
      vs1_q     <= '0;
    end else begin
      s1_v <= state == ISSUE;
      s1_k <= k;
      if (state == ISSUE) prod <= prod_d;
      if (s1_v) vd_bus[s1_k*VLEN_BITS +: VLEN_BITS] <= res;
      case (state)
        IDLE: if (in_valid) begin
          vs2_q    <= vs2_bus;
          vs1_q    <= vs1_bus;
          vd_bus   <= acc_bus;
          sew_q    <= sew;
          vl_q     <= 32'(vl) > vlmax ? vlmax : 32'(vl);
          last_q   <= 3'((4'd1 << lmul) - 4'd1);
          err      <= !legal;
          in_ready <= 1'b0;
          state    <= legal ? ISSUE : DONE;
        end
        ISSUE: begin
          k <= k == last_q ? 3'd0 : k + 3'd1;
          if (k == last_q) state <= DRAIN;
        end
        DRAIN: begin
          out_valid <= 1'b1;
          state     <= DONE;
        end
        default: begin
          out_valid <= 1'b1;
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vmacc_seq_unit.sv
// tb_vmacc_seq_unit: table-driven scoreboard bench for vmacc_seq_unit (default unsigned build)
module tb_vmacc_seq_unit;
  localparam int VLEN = 128;
  localparam int ML = 4;
  localparam int W = VLEN * ML;
  typedef struct {
    logic [1:0]  sew;
    logic [1:0]  lmul;
    logic [15:0] vl;
    logic [31:0] a, b, c;
    bit          rnd;
    logic [31:0] e0;
    logic        err;
    int          lat;
  } vec_t;
  typedef struct {
    logic [W-1:0] vd;
    logic         err;
    int           lat;
    logic [31:0]  e0;
    bit           rnd;
    logic [1:0]   sew;
  } exp_t;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, err;
  logic [1:0] sew, lmul;
  logic [15:0] vl;
  logic [W-1:0] vs2_bus, vs1_bus, acc_bus, vd_bus;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  vec_t tbl[10];
  always #5 clk = ~clk;
  vmacc_seq_unit #(.VLEN_BITS(VLEN), .MAX_LMUL(ML)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sew(sew), .lmul(lmul), .vl(vl),
    .vs2_bus(vs2_bus), .vs1_bus(vs1_bus), .acc_bus(acc_bus), .out_valid(out_valid), .out_ready(out_ready),
    .vd_bus(vd_bus), .err(err)
  );
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] emask(input logic [1:0] s);
    return s == 2'd1 ? 32'hFFFF : s == 2'd2 ? 32'hFFFF_FFFF : 32'hFF;
  endfunction
  function automatic logic [W-1:0] fill(input logic [31:0] v, input logic [1:0] s);
    int e;
    logic [W-1:0] r;
    e = s == 2'd3 ? 8 : 8 << s;
    r = '0;
    for (int i = 0; i < W / e; i++) r |= W'(v & emask(s)) << (i * e);
    return r;
  endfunction
  function automatic exp_t model(input vec_t v, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    exp_t x;
    int e, n, ve;
    logic [31:0] m, ea, eb, ec, r;
    n = 1 << v.lmul;
    e = 8 << v.sew;
    m = emask(v.sew);
    x.vd = c; x.err = v.err; x.lat = v.lat; x.e0 = v.e0; x.rnd = v.rnd; x.sew = v.sew;
    if (v.sew != 2'd3 && n <= ML) begin
      ve = n * VLEN / e;
      if (int'(v.vl) < ve) ve = int'(v.vl);
      for (int i = 0; i < ve; i++) begin
        ea = 32'(a >> (i * e)) & m;
        eb = 32'(b >> (i * e)) & m;
        ec = 32'(c >> (i * e)) & m;
        r = (ea * eb + ec) & m;
        x.vd = (x.vd & ~(W'(m) << (i * e))) | (W'(r) << (i * e));
      end
    end
    return x;
  endfunction
  task automatic operands(input vec_t v, output logic [W-1:0] a, output logic [W-1:0] b, output logic [W-1:0] c);
    a = fill(v.a, v.sew);
    b = fill(v.b, v.sew);
    c = fill(v.c, v.sew);
    if (v.rnd) for (int i = 0; i < W / 32; i++) begin
      a[i*32 +: 32] = $urandom;
      b[i*32 +: 32] = $urandom;
      c[i*32 +: 32] = $urandom;
    end
  endtask
  task automatic scramble();
    vs2_bus = ~vs2_bus; vs1_bus = ~vs1_bus; acc_bus = ~acc_bus; sew = ~sew; lmul = ~lmul; vl = ~vl;
  endtask
  task automatic apply(input vec_t v, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    sew = v.sew; lmul = v.lmul; vl = v.vl; vs2_bus = a; vs1_bus = b; acc_bus = c; in_valid = 1'b1;
  endtask
  task automatic drive(input vec_t v, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    int t = 0;
    @(negedge clk);
    apply(v, a, b, c);
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("accept_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    scramble();
  endtask
  task automatic wait_out(output logic [W-1:0] held);
    exp_t x;
    int lat = 1;
    x = q.pop_front();
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("out_valid", out_valid, 1);
    chk("latency", lat, x.lat);
    chk("err", err, x.err);
    chk("vd_bus", vd_bus, x.vd);
    if (!x.rnd) chk("elem0", vd_bus & W'(emask(x.sew)), W'(x.e0));
    held = vd_bus;
  endtask
  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask
  task automatic run(input vec_t v, input int hold);
    logic [W-1:0] a, b, c, held;
    operands(v, a, b, c);
    q.push_back(model(v, a, b, c));
    drive(v, a, b, c);
    wait_out(held);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_vd", vd_bus, held);
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    release_out();
    @(negedge clk);
    chk("idle_ready", in_ready, 1);
    chk("idle_valid", out_valid, 0);
  endtask
  task automatic back_to_back();
    logic [W-1:0] a, b, c, held;
    operands(tbl[0], a, b, c);
    q.push_back(model(tbl[0], a, b, c));
    drive(tbl[0], a, b, c);
    wait_out(held);
    operands(tbl[7], a, b, c);
    q.push_back(model(tbl[7], a, b, c));
    apply(tbl[7], a, b, c);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("b2b_in_ready", in_ready, 1);
    chk("b2b_out_valid", out_valid, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    scramble();
    wait_out(held);
    release_out();
  endtask
  task automatic abort_op();
    logic [W-1:0] a, b, c;
    bit seen = 1'b0;
    operands(tbl[1], a, b, c);
    drive(tbl[1], a, b, c);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_vd", vd_bus, 0);
    repeat (8) begin
      @(negedge clk);
      seen |= out_valid;
    end
    chk("abort_no_output", seen, 0);
  endtask
  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sew = '0; lmul = '0; vl = '0;
    vs2_bus = '0; vs1_bus = '0; acc_bus = '0;
    tbl[0] = '{2'd0, 2'd0, 16'd16,   32'd3,       32'd5,       32'd1,      1'b0, 32'h10,   1'b0, 3};
    tbl[1] = '{2'd2, 2'd2, 16'd16,   32'h10000,   32'h10000,   32'd7,      1'b0, 32'h7,    1'b0, 6};
    tbl[2] = '{2'd1, 2'd1, 16'd5,    32'd2,       32'd2,       32'hAAAA,   1'b0, 32'hAAAE, 1'b0, 4};
    tbl[3] = '{2'd0, 2'd3, 16'd16,   32'd3,       32'd5,       32'h5A,     1'b0, 32'h5A,   1'b1, 2};
    tbl[4] = '{2'd3, 2'd0, 16'd16,   32'd1,       32'd1,       32'h33,     1'b0, 32'h33,   1'b1, 2};
    tbl[5] = '{2'd2, 2'd0, 16'd0,    32'd5,       32'd6,       32'd9,      1'b0, 32'h9,    1'b0, 3};
    tbl[6] = '{2'd0, 2'd2, 16'd1000, 32'hFF,      32'hFF,      32'h02,     1'b0, 32'h03,   1'b0, 6};
    tbl[7] = '{2'd1, 2'd0, 16'd8,    32'h1234,    32'h0101,    32'hFFFF,   1'b0, 32'h4633, 1'b0, 3};
    tbl[8] = '{2'd1, 2'd2, 16'd20,   32'd0,       32'd0,       32'd0,      1'b1, 32'd0,    1'b0, 6};
    tbl[9] = '{2'd0, 2'd1, 16'd40,   32'd0,       32'd0,       32'd0,      1'b1, 32'd0,    1'b0, 4};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_err", err, 0);
    chk("reset_vd", vd_bus, 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) run(tbl[i], i == 1 ? 5 : 0);
    back_to_back();
    abort_op();
    run(tbl[2], 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
